// File: rtl/instruction_sequencer_pkg.sv
// InstructionSetPkg: shared instruction-set definitions for the sequencer,
// its register file and the ALU that sits beside it.
//   - operand/immediate widths and the instruction word layout
//     {opcode[19:16], dest[15:12], src[11:8], imm[7:0]}
//   - eOperation (operation handed to the ALU) and sFlags (flags register)
//   - decode_opcode(): opcode -> {legal, eOperation}
//   - wrap_index(): register index folded into the populated register file
package InstructionSetPkg;

    localparam int DataWidth      = 16;
    localparam int ImmediateWidth = 8;
    localparam int OpcodeWidth    = 4;
    localparam int RegAddrWidth   = 4;
    localparam int InstrWidth     = OpcodeWidth + 2 * RegAddrWidth + ImmediateWidth;

    localparam int ImmLsb    = 0;
    localparam int SrcLsb    = ImmLsb + ImmediateWidth;
    localparam int DestLsb   = SrcLsb + RegAddrWidth;
    localparam int OpcodeLsb = DestLsb + RegAddrWidth;

    typedef enum logic [3:0] {
        MOVE = 4'd0,
        LIL  = 4'd1,
        ADD  = 4'd2,
        ADC  = 4'd3,
        SUB  = 4'd4,
        AND  = 4'd5,
        OR   = 4'd6,
        XOR  = 4'd7,
        DIV  = 4'd8,
        MOD  = 4'd9
    } eOperation;

    typedef struct packed {
        logic Negative;
        logic Zero;
        logic Carry;
    } sFlags;

    typedef struct packed {
        logic      legal;
        eOperation op;
    } sDecoded;

    // Opcodes 10..15 are unassigned and come back with legal=0.
    function automatic sDecoded decode_opcode(input logic [OpcodeWidth-1:0] opcode);
        sDecoded d;
        d = '{legal: 1'b1, op: MOVE};
        case (opcode)
            4'h0:    d.op = MOVE;
            4'h1:    d.op = LIL;
            4'h2:    d.op = ADD;
            4'h3:    d.op = ADC;
            4'h4:    d.op = SUB;
            4'h5:    d.op = AND;
            4'h6:    d.op = OR;
            4'h7:    d.op = XOR;
            4'h8:    d.op = DIV;
            4'h9:    d.op = MOD;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    // Register fields are always RegAddrWidth wide; smaller register files
    // alias the upper indices back onto the populated entries.
    function automatic int unsigned wrap_index(input logic [RegAddrWidth-1:0] idx,
                                               input int unsigned num_regs);
        return 32'(idx) % num_regs;
    endfunction

endpackage

// File: rtl/instruction_sequencer_register_file.sv
// register_file: NumRegs x DataWidth storage, two asynchronous read ports and
// one synchronous write port. Synchronous active-high reset clears every entry.
//   clk_i, rst_i          clock, synchronous reset
//   raddr_a_i/rdata_a_o   read port A
//   raddr_b_i/rdata_b_o   read port B
//   we_i, waddr_i, wdata_i write port, written on the rising edge
module register_file #(
    parameter int NumRegs   = 8,
    parameter int DataWidth = 16,
    parameter int IdxW      = $clog2(NumRegs)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IdxW-1:0]      raddr_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    input  logic [IdxW-1:0]      raddr_b_i,
    output logic [DataWidth-1:0] rdata_b_o,
    input  logic                 we_i,
    input  logic [IdxW-1:0]      waddr_i,
    input  logic [DataWidth-1:0] wdata_i
);

    logic [DataWidth-1:0] regs_q [NumRegs];

    // NOTE: the array is reset because architecturally every register reads
    // 0 after reset; this costs a flop-based array instead of a RAM macro.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: non-overlapped FETCH->DECODE->EXECUTE->WRITEBACK
// controller driving an external combinational ALU.
//   Clock, Reset                 clock, synchronous active-high reset
//   InstrValid/InstrReady/Instr  instruction handshake (ready only in FETCH)
//   Operation, AluSrc, AluDest,
//   AluImm, AluInFlags           registered ALU operands, stable in EXECUTE
//   AluOutDest, AluOutFlags      ALU result, captured at the end of EXECUTE
//   ResultValid/ResultReg/
//   ResultData                   one-cycle writeback strobe in WRITEBACK
//   Flags                        architectural flags register
//   Fault                        one-cycle strobe: illegal opcode or x/0, x%0
module instruction_sequencer
    import InstructionSetPkg::*;
#(
    parameter int NumRegs = 8
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic                             InstrValid,
    output logic                             InstrReady,
    input  logic [InstrWidth-1:0]            Instr,
    output eOperation                        Operation,
    output logic signed [DataWidth-1:0]      AluSrc,
    output logic signed [DataWidth-1:0]      AluDest,
    output logic signed [ImmediateWidth-1:0] AluImm,
    output sFlags                            AluInFlags,
    input  logic [DataWidth-1:0]             AluOutDest,
    input  sFlags                            AluOutFlags,
    output logic                             ResultValid,
    output logic [RegAddrWidth-1:0]          ResultReg,
    output logic [DataWidth-1:0]             ResultData,
    output sFlags                            Flags,
    output logic                             Fault
);

    localparam int IdxW = $clog2(NumRegs);

    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} eState;

    eState                state_q;
    logic [InstrWidth-1:0] instr_q;
    logic                 legal_q;
    sFlags                res_flags_q;

    logic [IdxW-1:0]      src_idx;
    logic [IdxW-1:0]      dest_idx;
    logic [DataWidth-1:0] src_data;
    logic [DataWidth-1:0] dest_data;
    sDecoded              dec;
    logic                 div_zero;

    assign src_idx  = IdxW'(wrap_index(instr_q[SrcLsb +: RegAddrWidth], NumRegs));
    assign dest_idx = IdxW'(wrap_index(instr_q[DestLsb +: RegAddrWidth], NumRegs));
    assign dec      = decode_opcode(instr_q[OpcodeLsb +: OpcodeWidth]);

    // The divisor is the source operand, already registered for EXECUTE.
    assign div_zero = ((Operation == DIV) || (Operation == MOD)) && (AluSrc == '0);

    // ResultValid is only ever high in WRITEBACK, so it doubles as the
    // register-file write enable; a fault leaves it low and blocks the write.
    register_file #(
        .NumRegs   (NumRegs),
        .DataWidth (DataWidth),
        .IdxW      (IdxW)
    ) u_register_file (
        .clk_i     (Clock),
        .rst_i     (Reset),
        .raddr_a_i (src_idx),
        .rdata_a_o (src_data),
        .raddr_b_i (dest_idx),
        .rdata_b_o (dest_data),
        .we_i      (ResultValid),
        .waddr_i   (ResultReg[IdxW-1:0]),
        .wdata_i   (ResultData)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= FETCH;
            InstrReady  <= 1'b1;
            instr_q     <= '0;
            legal_q     <= 1'b0;
            Operation   <= MOVE;
            AluSrc      <= '0;
            AluDest     <= '0;
            AluImm      <= '0;
            AluInFlags  <= '0;
            res_flags_q <= '0;
            ResultValid <= 1'b0;
            ResultReg   <= '0;
            ResultData  <= '0;
            Flags       <= '0;
            Fault       <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (InstrValid && InstrReady) begin
                        instr_q    <= Instr;
                        InstrReady <= 1'b0;
                        state_q    <= DECODE;
                    end
                end
                DECODE: begin
                    // Both operands come from the same pre-instruction
                    // register state, so src==dest needs no special case.
                    Operation  <= dec.op;
                    legal_q    <= dec.legal;
                    AluSrc     <= src_data;
                    AluDest    <= dest_data;
                    AluImm     <= instr_q[ImmLsb +: ImmediateWidth];
                    AluInFlags <= Flags;
                    state_q    <= EXECUTE;
                end
                EXECUTE: begin
                    ResultData  <= AluOutDest;
                    res_flags_q <= AluOutFlags;
                    ResultReg   <= RegAddrWidth'(dest_idx);
                    ResultValid <= legal_q && !div_zero;
                    Fault       <= !legal_q || div_zero;
                    state_q     <= WRITEBACK;
                end
                WRITEBACK: begin
                    if (ResultValid) begin
                        Flags <= res_flags_q;
                    end
                    ResultValid <= 1'b0;
                    Fault       <= 1'b0;
                    InstrReady  <= 1'b1;
                    state_q     <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer. The bench supplies the ALU
// (a combinational behavioural model) and keeps its own architectural model
// of the register file and flags, against which every instruction's operands,
// writeback, fault and flags are compared.
module tb_instruction_sequencer;
    import InstructionSetPkg::*;

    localparam int NumRegs = 8;

    typedef struct packed {
        logic [DataWidth-1:0] res;
        sFlags                flags;
    } alu_out_t;

    logic                             Clock;
    logic                             Reset;
    logic                             InstrValid;
    logic                             InstrReady;
    logic [InstrWidth-1:0]            Instr;
    eOperation                        Operation;
    logic signed [DataWidth-1:0]      AluSrc;
    logic signed [DataWidth-1:0]      AluDest;
    logic signed [ImmediateWidth-1:0] AluImm;
    sFlags                            AluInFlags;
    logic [DataWidth-1:0]             AluOutDest;
    sFlags                            AluOutFlags;
    logic                             ResultValid;
    logic [RegAddrWidth-1:0]          ResultReg;
    logic [DataWidth-1:0]             ResultData;
    sFlags                            Flags;
    logic                             Fault;

    int total = 0;
    int bad   = 0;

    logic [DataWidth-1:0] model_regs [NumRegs];
    sFlags                model_flags;
    alu_out_t             alu_o;

    instruction_sequencer #(.NumRegs(NumRegs)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .Instr       (Instr),
        .Operation   (Operation),
        .AluSrc      (AluSrc),
        .AluDest     (AluDest),
        .AluImm      (AluImm),
        .AluInFlags  (AluInFlags),
        .AluOutDest  (AluOutDest),
        .AluOutFlags (AluOutFlags),
        .ResultValid (ResultValid),
        .ResultReg   (ResultReg),
        .ResultData  (ResultData),
        .Flags       (Flags),
        .Fault       (Fault)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural ALU: dest <- f(dest, src, imm, flags).
    function automatic alu_out_t alu_model(input eOperation op, input logic [15:0] d,
                                           input logic [15:0] s, input logic [7:0] imm,
                                           input sFlags fin);
        alu_out_t   o;
        logic [16:0] wide;
        o = '0;
        wide = '0;
        case (op)
            MOVE: o.res = s;
            LIL:  o.res = {d[15:8], imm};
            ADD:  begin wide = {1'b0, d} + {1'b0, s}; o.res = wide[15:0]; o.flags.Carry = wide[16]; end
            ADC:  begin wide = {1'b0, d} + {1'b0, s} + {16'b0, fin.Carry}; o.res = wide[15:0]; o.flags.Carry = wide[16]; end
            SUB:  begin wide = {1'b0, d} - {1'b0, s}; o.res = wide[15:0]; o.flags.Carry = wide[16]; end
            AND:  o.res = d & s;
            OR:   o.res = d | s;
            XOR:  o.res = d ^ s;
            DIV:  o.res = (s == 0) ? 16'h0 : d / s;
            MOD:  o.res = (s == 0) ? 16'h0 : d % s;
            default: o.res = s;
        endcase
        o.flags.Zero     = (o.res == 16'h0);
        o.flags.Negative = o.res[15];
        return o;
    endfunction

    assign alu_o       = alu_model(Operation, $unsigned(AluDest), $unsigned(AluSrc),
                                   $unsigned(AluImm), AluInFlags);
    assign AluOutDest  = alu_o.res;
    assign AluOutFlags = alu_o.flags;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NumRegs; i++) model_regs[i] = '0;
        model_flags = '0;
    endtask

    function automatic logic [InstrWidth-1:0] mk_instr(input logic [3:0] opc, input logic [3:0] dst,
                                                       input logic [3:0] src, input logic [7:0] imm);
        logic [InstrWidth-1:0] w;
        w = '0;
        w[OpcodeLsb +: OpcodeWidth]  = opc;
        w[DestLsb +: RegAddrWidth]   = dst;
        w[SrcLsb +: RegAddrWidth]    = src;
        w[ImmLsb +: ImmediateWidth]  = imm;
        return w;
    endfunction

    // Issue one instruction from a FETCH cycle and check every stage.
    task automatic run_instr(input logic [3:0] opc, input logic [3:0] dst,
                             input logic [3:0] src, input logic [7:0] imm);
        int        di;
        int        si;
        int        n;
        bit        legal;
        bit        divz;
        eOperation op;
        alu_out_t  exp;
        di    = int'(dst) % NumRegs;
        si    = int'(src) % NumRegs;
        legal = (opc <= 4'd9);
        op    = legal ? eOperation'(opc) : MOVE;
        exp   = alu_model(op, model_regs[di], model_regs[si], imm, model_flags);
        divz  = legal && (op == DIV || op == MOD) && (model_regs[si] == 16'h0);

        Instr      = mk_instr(opc, dst, src, imm);
        InstrValid = 1'b1;
        n = 0;
        while (!InstrReady && n < 10) begin
            cycle();
            n++;
        end
        check("ready_before_accept", InstrReady, 1);
        cycle();                                  // handshake edge k -> DECODE
        InstrValid = 1'b0;
        check("ready_in_decode", InstrReady, 0);
        check("valid_in_decode", ResultValid, 0);
        cycle();                                  // k+2 EXECUTE
        if (legal) check("operation", Operation, op);
        check("alu_src", $unsigned(AluSrc), model_regs[si]);
        check("alu_dest", $unsigned(AluDest), model_regs[di]);
        check("alu_imm", $unsigned(AluImm), imm);
        check("alu_in_flags", AluInFlags, model_flags);
        cycle();                                  // k+3 WRITEBACK
        check("result_valid", ResultValid, legal && !divz);
        check("fault", Fault, !legal || divz);
        if (legal && !divz) begin
            check("result_reg", ResultReg, di);
            check("result_data", ResultData, exp.res);
            model_regs[di] = exp.res;
            model_flags    = exp.flags;
        end
        cycle();                                  // k+4 FETCH
        check("ready_after_wb", InstrReady, 1);
        check("valid_after_wb", ResultValid, 0);
        check("fault_after_wb", Fault, 0);
        check("flags", Flags, model_flags);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepted;
        Reset      = 1'b1;
        InstrValid = 1'b0;
        Instr      = '0;
        model_reset();

        // Reset state.
        cycle();
        cycle();
        check("rst_ready", InstrReady, 1);
        check("rst_valid", ResultValid, 0);
        check("rst_fault", Fault, 0);
        check("rst_result_reg", ResultReg, 0);
        check("rst_result_data", ResultData, 0);
        check("rst_operation", Operation, MOVE);
        check("rst_alu_src", $unsigned(AluSrc), 0);
        check("rst_alu_dest", $unsigned(AluDest), 0);
        check("rst_alu_imm", $unsigned(AluImm), 0);
        check("rst_alu_in_flags", AluInFlags, 0);
        check("rst_flags", Flags, 0);
        Reset = 1'b0;
        cycle();
        check("ready_after_release", InstrReady, 1);

        // LIL r1,5 then MOVE r2,r1.
        run_instr(4'h1, 4'd1, 4'd0, 8'd5);
        check("lil_r1_is_5", model_regs[1], 16'd5);
        run_instr(4'h0, 4'd2, 4'd1, 8'd0);

        // ADC r2,r1 with r1=3, r2=4, Carry=0.
        run_instr(4'h1, 4'd1, 4'd0, 8'd3);
        run_instr(4'h1, 4'd2, 4'd0, 8'd4);
        run_instr(4'h3, 4'd2, 4'd1, 8'd0);
        check("adc_flags", Flags, 3'b000);

        // DIV r3,r1 with r1=0 -> fault, nothing written.
        run_instr(4'h1, 4'd1, 4'd0, 8'd0);
        run_instr(4'h1, 4'd3, 4'd0, 8'd9);
        run_instr(4'h8, 4'd3, 4'd1, 8'd0);
        run_instr(4'h0, 4'd0, 4'd3, 8'd0);        // r3 still 9 (seen as AluSrc)

        // Illegal opcode.
        run_instr(4'hC, 4'd2, 4'd1, 8'hAA);

        // src == dest, and index wrap (9 -> r1 with 8 registers).
        run_instr(4'h1, 4'd4, 4'd0, 8'h40);
        run_instr(4'h2, 4'd4, 4'd4, 8'd0);
        run_instr(4'h1, 4'd9, 4'd0, 8'h22);
        run_instr(4'h0, 4'd0, 4'd9, 8'd0);

        // InstrValid held for 8 cycles: two acceptances, ready only in FETCH.
        Instr      = mk_instr(4'h0, 4'd5, 4'd1, 8'd0);
        InstrValid = 1'b1;
        accepted   = 0;
        for (int i = 0; i < 8; i++) begin
            check("stream_ready", InstrReady, (i % 4) == 0);
            if (InstrReady) accepted++;
            cycle();
        end
        InstrValid = 1'b0;
        check("stream_accepted", accepted, 2);
        for (int i = 0; i < 2; i++) begin
            alu_out_t o;
            o = alu_model(MOVE, model_regs[5], model_regs[1], 8'd0, model_flags);
            model_regs[5] = o.res;
            model_flags   = o.flags;
        end
        check("stream_flags", Flags, model_flags);
        run_instr(4'h0, 4'd0, 4'd5, 8'd0);

        // Reset during EXECUTE aborts the instruction.
        Instr      = mk_instr(4'h1, 4'd6, 4'd0, 8'h7F);
        InstrValid = 1'b1;
        check("abort_ready", InstrReady, 1);
        cycle();
        InstrValid = 1'b0;
        cycle();
        check("abort_in_execute", Operation, LIL);
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        model_reset();
        check("abort_valid", ResultValid, 0);
        check("abort_fault", Fault, 0);
        check("abort_ready_next", InstrReady, 1);
        cycle();
        check("abort_valid_2", ResultValid, 0);
        check("abort_fault_2", Fault, 0);
        check("abort_ready_2", InstrReady, 1);
        check("abort_flags", Flags, 0);
        for (int i = 0; i < NumRegs; i++) begin
            run_instr(4'h0, 4'd0, 4'(i), 8'd0);
        end

        // Randomised instruction stream.
        for (int i = 0; i < 48; i++) begin
            run_instr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter NumRegs, default 8, meaning register-file depth (power of two, 2..16).
REQ-002 SHALL have port Clock, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port InstrValid, input, 1, instruction word offered.
REQ-005 SHALL have port InstrReady, output, 1, sequencer accepts an instruction this cycle.
REQ-006 SHALL have port Instr, input, InstrWidth, instruction word {opcode, dest reg, src reg, immediate}.
REQ-007 SHALL have port Operation, output, eOperation, operation driven to the ALU.
REQ-008 SHALL have ports AluSrc and AluDest, output, DataWidth (signed), source and destination operands to the ALU.
REQ-009 SHALL have port AluImm, output, ImmediateWidth (signed), immediate to the ALU.
REQ-010 SHALL have port AluInFlags, output, sFlags, current flags to the ALU.
REQ-011 SHALL have port AluOutDest, input, DataWidth, ALU result.
REQ-012 SHALL have port AluOutFlags, input, sFlags, ALU flags.
REQ-013 SHALL have port ResultValid, output, 1, single-cycle writeback strobe.
REQ-014 SHALL have port ResultReg, output, RegAddrWidth, register written.
REQ-015 SHALL have port ResultData, output, DataWidth, value written.
REQ-016 SHALL have port Flags, output, sFlags, architectural flags register.
REQ-017 SHALL have port Fault, output, 1, single-cycle strobe for an illegal opcode or divide-by-zero.

Function
REQ-018 SHALL implement the FSM FETCH->DECODE->EXECUTE->WRITEBACK->FETCH, advancing one state per cycle.
REQ-019 SHALL assert InstrReady only in FETCH and SHALL latch Instr and leave FETCH only when InstrValid&&InstrReady; otherwise it SHALL hold FETCH.
REQ-020 SHALL, in DECODE, map opcode to eOperation, read regs[src] and regs[dest], and register Operation/AluSrc/AluDest/AluImm/AluInFlags; these SHALL stay stable through EXECUTE.
REQ-021 SHALL, in EXECUTE, capture AluOutDest and AluOutFlags into internal result registers; the ALU is purely combinational.
REQ-022 SHALL, in WRITEBACK, assert ResultValid with ResultReg/ResultData, write regs[dest] and load Flags from the captured flags at the end of that cycle.
REQ-023 SHALL produce an accept-to-ResultValid latency of exactly 3 cycles (handshake edge k, ResultValid high in cycle k+3, InstrReady high again in cycle k+4) and a throughput of one instruction per 4 cycles.
REQ-024 SHALL treat an unmapped opcode as illegal: no register or Flags write, ResultValid low, Fault high in the WRITEBACK cycle.
REQ-025 SHALL treat DIV or MOD with a source operand of 0 as a fault: no register or Flags write, Fault high in WRITEBACK, ResultValid low.
REQ-026 SHALL handle src==dest correctly by reading both operands from the same pre-instruction value.
REQ-027 SHALL wrap register indices modulo NumRegs.
REQ-028 SHALL ensure an instruction observes all writes of the previous instruction; no forwarding is needed because execution is non-overlapped.

Reset
REQ-029 SHALL, on Reset, enter FETCH, clear all registers and Flags to 0, and clear InstrReady's prior state, driving InstrReady=1 in the first cycle after release.
REQ-030 SHALL, on Reset, drive ResultValid=0, Fault=0, ResultReg=0, ResultData=0, Operation=MOVE, AluSrc=AluDest=AluImm=0 and AluInFlags=0.
REQ-031 SHALL abort an in-flight instruction when Reset occurs mid-operation, with no writeback and no Fault.

Structure
REQ-032 SHALL source DataWidth, ImmediateWidth, eOperation and sFlags from InstructionSetPkg, and InstructionSetPkg SHALL also hold InstrWidth, OpcodeWidth, RegAddrWidth, the instruction field positions and the opcode-to-eOperation decode function.
REQ-033 SHALL define the FSM state enum locally within the module.
REQ-034 SHALL instantiate no ALU; the ALU is a peer connected at top level, and one sub-module, register_file (2 read ports, 1 write port, synchronous write), is natural.

Verification
REQ-035 SHALL verify: Reset then LIL r1,imm=5 -> ResultValid in cycle k+3, ResultReg=1, ResultData=5, then MOVE r2,r1 -> r2=5.
REQ-036 SHALL verify: r1=3, r2=4, Carry=0, ADC r2,r1 -> ResultData=7, Zero=0 and Carry=0 in Flags after WRITEBACK.
REQ-037 SHALL verify: r1=0, DIV r3,r1 -> Fault pulse, r3 and Flags unchanged, ResultValid stays 0.
REQ-038 SHALL verify: InstrValid held high for 8 cycles -> exactly 2 instructions accepted, with InstrReady high only in the FETCH cycles.
REQ-039 SHALL verify: Reset asserted in EXECUTE -> no ResultValid or Fault, all registers 0, and InstrReady=1 in the next cycle.
REQ-040 SHALL verify: an illegal opcode -> Fault in cycle k+3 and no register change.
